// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: owner FSM states and access sizes.
package mem_port_arbiter_pkg;

  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_I_RD = 2'd1;
  localparam logic [1:0] OWN_D_RD = 2'd2;
  localparam logic [1:0] OWN_D_WR = 2'd3;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating count of consecutive cycles the fetch port was denied; at_max forces a fetch grant.
module arb_starve_cnt #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == CNT_W'(STARVE_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous memory between fetch and load/store ports,
// one access per cycle, data port first, with a starvation bound for fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STORE_M    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [DATA_W-1:0]  i_rdata,
  output logic               i_valid,
  output logic               i_stall,
  input  logic               d_rd_req,
  input  logic               d_wr_req,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  input  logic [STORE_M-1:0] d_mode,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               d_valid,
  output logic               d_stall,
  output logic               err,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [STORE_M-1:0] mem_mode,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata
);

  logic              d_req;
  logic              at_max;
  logic              fetch_grant;
  logic              data_grant;
  logic [1:0]        owner_q, owner_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  assign d_req       = d_rd_req | d_wr_req;
  assign fetch_grant = i_req & (at_max | ~d_req);
  assign data_grant  = d_req & ~(at_max & i_req);

  assign i_stall = i_req & ~fetch_grant;
  assign d_stall = d_req & ~data_grant;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (i_req & ~fetch_grant),
    .clr_i    (~i_req | fetch_grant),
    .at_max_o (at_max)
  );

  // A simultaneous read+write request is issued as a write.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_mode  = '0;
    mem_wdata = '0;
    owner_d   = OWN_IDLE;
    if (fetch_grant) begin
      mem_en   = 1'b1;
      mem_addr = i_addr;
      mem_mode = STORE_M'(MODE_WORD);
      owner_d  = OWN_I_RD;
    end else if (data_grant) begin
      mem_en    = 1'b1;
      mem_we    = d_wr_req;
      mem_addr  = d_addr;
      mem_mode  = d_mode;
      mem_wdata = d_wdata;
      owner_d   = d_wr_req ? OWN_D_WR : OWN_D_RD;
    end
  end

  assign err_d = err_q | (d_rd_req & d_wr_req);
  assign err   = err_q;

  // Response cycle: memory data is live while owner names the reader; hold it afterwards.
  assign i_valid = (owner_q == OWN_I_RD);
  assign d_valid = (owner_q == OWN_D_RD) || (owner_q == OWN_D_WR);
  assign i_rdata = (owner_q == OWN_I_RD) ? mem_rdata : i_rdata_q;
  assign d_rdata = (owner_q == OWN_D_RD) ? mem_rdata : d_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q   <= OWN_IDLE;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
      if (owner_q == OWN_I_RD) begin
        i_rdata_q <= mem_rdata;
      end
      if (owner_q == OWN_D_RD) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

endmodule
